axis_pattern_source: RTL and testbench

- AXI-Stream packet generator that sits directly upstream of the stream loopback FIFO path and drives its input stream (tuser/tvalid/tready/tlast/tdata).
- Emits packets of programmable length, separated by a programmable idle gap.
- Data is a deterministic incrementing pattern, so a downstream checker can verify ordering and loss.
- Control fields arrive as quasi-static levels from a register-map control word.

---
 rtl/axis_pattern_source_pkg.sv | 23 ++
 rtl/axis_pattern_lfsr.sv | 29 ++
 rtl/axis_pattern_source.sv | 188 ++++++++++++++++++
 tb/tb_axis_pattern_source.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_pattern_source_pkg.sv
// Shared definitions for the AXI-Stream pattern source: FSM state encoding,
// LFSR polynomial/seed and the single-step LFSR helper.
package axis_pattern_source_pkg;

   // Generator FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Galois LFSR taps for x^32+x^22+x^2+x+1 (right-shifting form)
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
   localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

   // One Galois LFSR step: shift right, fold the taps in when a one falls out
   function automatic logic [31:0] lfsrStep(input logic [31:0] state);
      logic [31:0] shifted;
      shifted = state >> 1;
      return state[0] ? (shifted ^ LFSR_POLY) : shifted;
   endfunction

endpackage

// File: rtl/axis_pattern_lfsr.sv
// 32-bit Galois LFSR used as the alternative data pattern of the
// AXI-Stream pattern source. Advances only when stepped; clear and reset
// both return it to the seed.
module axis_pattern_lfsr
   import axis_pattern_source_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_step,
   input  logic        i_clear,
   output logic [31:0] o_state
);

   logic [31:0] r_state;

   // Clear has priority over a step landing on the same edge
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= LFSR_SEED;
      end else if (i_clear) begin
         r_state <= LFSR_SEED;
      end else if (i_step) begin
         r_state <= lfsrStep(r_state);
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/axis_pattern_source.sv
// AXI-Stream packet generator: emits packets of programmable length with a
// programmable idle gap between them, carrying a deterministic data pattern.
// Optional build macro AXIS_PATTERN_SOURCE_LFSR_EN swaps the incrementing
// pattern for a 32-bit Galois LFSR (axis_pattern_lfsr).
module axis_pattern_source
   import axis_pattern_source_pkg::*;
#(
   parameter int AXIS_DATA_WIDTH = 32,
   parameter int LEN_WIDTH       = 16,
   parameter int GAP_WIDTH       = 8,
   parameter int CNT_WIDTH       = 32
)
(
   input  logic                       i_axis_clk,
   input  logic                       i_axis_rst,
   input  logic                       i_enable,
   input  logic [LEN_WIDTH-1:0]       i_pkt_len,
   input  logic [GAP_WIDTH-1:0]       i_gap_len,
   input  logic                       i_clear,
   output logic                       o_axis_tuser,
   output logic                       o_axis_tvalid,
   input  logic                       i_axis_tready,
   output logic                       o_axis_tlast,
   output logic [AXIS_DATA_WIDTH-1:0] o_axis_tdata,
   output logic                       o_busy,
   output logic [CNT_WIDTH-1:0]       o_pkt_count
);

   state_t               r_state;
   logic [LEN_WIDTH-1:0] r_len;
   logic [LEN_WIDTH-1:0] r_beatIdx;
   logic [GAP_WIDTH-1:0] r_gap;
   logic [GAP_WIDTH-1:0] r_gapCnt;
   logic                 r_tvalid;
   logic                 r_tuser;
   logic                 r_tlast;
   logic                 r_busy;
   logic                 r_clrPend;
   logic [CNT_WIDTH-1:0] r_pktCount;

   logic                 w_accept;
   logic                 w_patStep;
   logic                 w_tlastAccept;
   logic                 w_patClear;
   logic                 w_gapDone;
   logic                 w_startPkt;
   logic [LEN_WIDTH-1:0] w_lenEff;
   logic [LEN_WIDTH-1:0] w_nextIdx;

   // Decode handshake, packet boundaries, clear application and packet starts
   always_comb begin
      w_accept      = r_tvalid & i_axis_tready;
      w_patStep     = (r_state == ST_SEND) && w_accept;
      w_tlastAccept = w_patStep && r_tlast;
      w_lenEff      = (i_pkt_len == '0) ? LEN_WIDTH'(1) : i_pkt_len;
      w_nextIdx     = r_beatIdx + LEN_WIDTH'(1);
      w_gapDone     = (r_state == ST_GAP) && (r_gapCnt == GAP_WIDTH'(1));
      // A clear seen while a packet is in flight waits for its tlast
      w_patClear    = ((r_state != ST_SEND) && i_clear) ||
                      (w_tlastAccept && (r_clrPend || i_clear));
      w_startPkt    = ((r_state == ST_IDLE) && i_enable) ||
                      (w_gapDone && i_enable) ||
                      (w_tlastAccept && (r_gap == '0) && i_enable);
   end

   // Packet FSM; a new packet start re-latches length/gap and wins over
   // every other transition so back-to-back packets keep tvalid high
   always_ff @(posedge i_axis_clk or negedge i_axis_rst) begin
      if (!i_axis_rst) begin
         r_state   <= ST_IDLE;
         r_len     <= '0;
         r_beatIdx <= '0;
         r_gap     <= '0;
         r_gapCnt  <= '0;
         r_tvalid  <= 1'b0;
         r_tuser   <= 1'b0;
         r_tlast   <= 1'b0;
         r_busy    <= 1'b0;
      end else if (w_startPkt) begin
         r_state   <= ST_SEND;
         r_busy    <= 1'b1;
         r_len     <= w_lenEff;
         r_gap     <= i_gap_len;
         r_beatIdx <= '0;
         r_tvalid  <= 1'b1;
         r_tuser   <= 1'b1;
         r_tlast   <= (w_lenEff == LEN_WIDTH'(1));
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state <= ST_IDLE;
            end
            ST_SEND: begin
               if (w_accept) begin
                  r_beatIdx <= w_nextIdx;
                  r_tuser   <= 1'b0;
                  if (r_tlast) begin
                     r_tvalid <= 1'b0;
                     r_tlast  <= 1'b0;
                     if (r_gap != '0) begin
                        r_state  <= ST_GAP;
                        r_gapCnt <= r_gap;
                     end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_tlast <= (w_nextIdx == (r_len - LEN_WIDTH'(1)));
                  end
               end
            end
            ST_GAP: begin
               if (w_gapDone) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_gapCnt <= r_gapCnt - GAP_WIDTH'(1);
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_busy   <= 1'b0;
               r_tvalid <= 1'b0;
               r_tuser  <= 1'b0;
               r_tlast  <= 1'b0;
            end
         endcase
      end
   end

   // Remember a clear that arrived mid-packet until the tlast beat goes out
   always_ff @(posedge i_axis_clk or negedge i_axis_rst) begin
      if (!i_axis_rst) begin
         r_clrPend <= 1'b0;
      end else if (w_tlastAccept) begin
         r_clrPend <= 1'b0;
      end else if ((r_state == ST_SEND) && i_clear) begin
         r_clrPend <= 1'b1;
      end
   end

   // Completed-packet counter; a clear on the same edge beats the increment
   always_ff @(posedge i_axis_clk or negedge i_axis_rst) begin
      if (!i_axis_rst) begin
         r_pktCount <= '0;
      end else if (w_patClear) begin
         r_pktCount <= '0;
      end else if (w_tlastAccept) begin
         r_pktCount <= r_pktCount + CNT_WIDTH'(1);
      end
   end

`ifdef AXIS_PATTERN_SOURCE_LFSR_EN
   logic [31:0] w_lfsrState;

   axis_pattern_lfsr u_lfsr (
      .i_clk   (i_axis_clk),
      .i_rst_n (i_axis_rst),
      .i_step  (w_patStep),
      .i_clear (w_patClear),
      .o_state (w_lfsrState)
   );

   assign o_axis_tdata = AXIS_DATA_WIDTH'(w_lfsrState);
`else
   logic [AXIS_DATA_WIDTH-1:0] r_pattern;

   // Incrementing data pattern, advanced once per accepted beat
   always_ff @(posedge i_axis_clk or negedge i_axis_rst) begin
      if (!i_axis_rst) begin
         r_pattern <= '0;
      end else if (w_patClear) begin
         r_pattern <= '0;
      end else if (w_patStep) begin
         r_pattern <= r_pattern + AXIS_DATA_WIDTH'(1);
      end
   end

   assign o_axis_tdata = r_pattern;
`endif

   assign o_axis_tvalid = r_tvalid;
   assign o_axis_tuser  = r_tuser;
   assign o_axis_tlast  = r_tlast;
   assign o_busy        = r_busy;
   assign o_pkt_count   = r_pktCount;

endmodule

// File: tb/tb_axis_pattern_source.sv
// Directed self-checking bench for axis_pattern_source (default build,
// incrementing pattern).
module tb_axis_pattern_source;

   logic        clk;
   logic        rstN;
   logic        enable;
   logic [15:0] pktLen;
   logic [7:0]  gapLen;
   logic        clear;
   logic        tready;
   logic        tuser;
   logic        tvalid;
   logic        tlast;
   logic [31:0] tdata;
   logic        busy;
   logic [31:0] pktCount;

   int testCount = 0;
   int failCount = 0;

   axis_pattern_source dut (
      .i_axis_clk    (clk),
      .i_axis_rst    (rstN),
      .i_enable      (enable),
      .i_pkt_len     (pktLen),
      .i_gap_len     (gapLen),
      .i_clear       (clear),
      .o_axis_tuser  (tuser),
      .o_axis_tvalid (tvalid),
      .i_axis_tready (tready),
      .o_axis_tlast  (tlast),
      .o_axis_tdata  (tdata),
      .o_busy        (busy),
      .o_pkt_count   (pktCount)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change and outputs are sampled on the falling edge
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic en, input logic [15:0] len,
                                input logic [7:0] gap, input logic rdy);
      enable = en;
      pktLen = len;
      gapLen = gap;
      tready = rdy;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkBeat(input string tag, input logic u, input logic l,
                            input logic [31:0] d);
      checkOutput({tag, " tvalid"}, 64'(tvalid), 64'(1'b1));
      checkOutput({tag, " tuser"},  64'(tuser),  64'(u));
      checkOutput({tag, " tlast"},  64'(tlast),  64'(l));
      checkOutput({tag, " tdata"},  64'(tdata),  64'(d));
   endtask

   initial begin
      rstN   = 1'b0;
      clear  = 1'b0;
      applyStimulus(1'b0, 16'd4, 8'd2, 1'b1);
      tick();
      tick();

      // Reset state
      checkOutput("rst tvalid", 64'(tvalid), 64'(0));
      checkOutput("rst tuser", 64'(tuser), 64'(0));
      checkOutput("rst tlast", 64'(tlast), 64'(0));
      checkOutput("rst tdata", 64'(tdata), 64'(0));
      checkOutput("rst busy", 64'(busy), 64'(0));
      checkOutput("rst count", 64'(pktCount), 64'(0));
      rstN = 1'b1;
      tick();
      checkOutput("idle busy", 64'(busy), 64'(0));

      // len=4 gap=2: two packets separated by two idle cycles
      applyStimulus(1'b1, 16'd4, 8'd2, 1'b1);
      tick();
      for (int i = 0; i < 4; i++) begin
         checkBeat($sformatf("p1 beat%0d", i), i == 0, i == 3, 32'(i));
         tick();
      end
      checkOutput("gap1 tvalid", 64'(tvalid), 64'(0));
      checkOutput("gap1 busy", 64'(busy), 64'(1));
      checkOutput("gap1 count", 64'(pktCount), 64'(1));
      tick();
      checkOutput("gap2 tvalid", 64'(tvalid), 64'(0));
      tick();
      for (int i = 4; i < 8; i++) begin
         checkBeat($sformatf("p2 beat%0d", i), i == 4, i == 7, 32'(i));
         if (i == 4) enable = 1'b0;
         tick();
      end
      checkOutput("p2 count", 64'(pktCount), 64'(2));
      checkOutput("p2 gap tvalid", 64'(tvalid), 64'(0));
      tick();
      tick();
      checkOutput("p2 idle busy", 64'(busy), 64'(0));

      // Clear in IDLE, then len=3 gap=0 with tready toggling
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checkOutput("clr idle count", 64'(pktCount), 64'(0));
      applyStimulus(1'b1, 16'd3, 8'd0, 1'b1);
      tick();
      for (int i = 0; i < 6; i++) begin
         checkBeat($sformatf("bb beat%0d", i), (i % 3) == 0, (i % 3) == 2, 32'(i));
         if (i == 3) enable = 1'b0;
         tready = 1'b0;
         tick();
         checkBeat($sformatf("bb stall%0d", i), (i % 3) == 0, (i % 3) == 2, 32'(i));
         tready = 1'b1;
         tick();
      end
      checkOutput("bb end tvalid", 64'(tvalid), 64'(0));
      checkOutput("bb end busy", 64'(busy), 64'(0));
      checkOutput("bb end count", 64'(pktCount), 64'(2));

      // pkt_len 0 then 1: every beat is a whole packet
      applyStimulus(1'b1, 16'd0, 8'd0, 1'b1);
      tick();
      for (int i = 0; i < 5; i++) begin
         checkBeat($sformatf("one beat%0d", i), 1'b1, 1'b1, 32'(6 + i));
         checkOutput($sformatf("one count%0d", i), 64'(pktCount), 64'(2 + i));
         if (i == 2) pktLen = 16'd1;
         if (i == 4) enable = 1'b0;
         tick();
      end
      checkOutput("one end busy", 64'(busy), 64'(0));
      checkOutput("one end count", 64'(pktCount), 64'(7));

      // Enable dropped after beat 1 of an 8-beat packet
      clear = 1'b1;
      tick();
      clear = 1'b0;
      applyStimulus(1'b1, 16'd8, 8'd0, 1'b1);
      tick();
      for (int i = 0; i < 8; i++) begin
         checkBeat($sformatf("drop beat%0d", i), i == 0, i == 7, 32'(i));
         if (i == 1) enable = 1'b0;
         tick();
      end
      checkOutput("drop tvalid", 64'(tvalid), 64'(0));
      checkOutput("drop busy", 64'(busy), 64'(0));
      checkOutput("drop count", 64'(pktCount), 64'(1));
      enable = 1'b1;
      tick();
      checkBeat("resume", 1'b1, 1'b0, 32'd8);

      // Asynchronous reset mid-packet
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("arst tvalid", 64'(tvalid), 64'(0));
      checkOutput("arst tuser", 64'(tuser), 64'(0));
      checkOutput("arst busy", 64'(busy), 64'(0));
      checkOutput("arst count", 64'(pktCount), 64'(0));
      checkOutput("arst tdata", 64'(tdata), 64'(0));
      tick();
      rstN = 1'b1;
      tick();
      enable = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checkBeat($sformatf("post beat%0d", i), i == 0, i == 7, 32'(i));
         tick();
      end
      checkOutput("post count", 64'(pktCount), 64'(1));
      checkOutput("post busy", 64'(busy), 64'(0));

      // Wrap through 0xFFFFFFFF with a clear requested mid-packet
      dut.r_pattern = 32'hFFFF_FFFE;
      applyStimulus(1'b1, 16'd3, 8'd1, 1'b1);
      tick();
      checkBeat("wrap beat0", 1'b1, 1'b0, 32'hFFFF_FFFE);
      clear = 1'b1;
      tick();
      clear  = 1'b0;
      enable = 1'b0;
      checkBeat("wrap beat1", 1'b0, 1'b0, 32'hFFFF_FFFF);
      checkOutput("wrap held count", 64'(pktCount), 64'(1));
      tick();
      checkBeat("wrap beat2", 1'b0, 1'b1, 32'h0000_0000);
      checkOutput("wrap pre-clr count", 64'(pktCount), 64'(1));
      tick();
      checkOutput("wrap clr count", 64'(pktCount), 64'(0));
      checkOutput("wrap gap tvalid", 64'(tvalid), 64'(0));
      enable = 1'b1;
      tick();
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checkBeat($sformatf("aftclr beat%0d", i), i == 0, i == 2, 32'(i));
         tick();
      end
      tick();
      checkOutput("aftclr busy", 64'(busy), 64'(0));
      checkOutput("aftclr count", 64'(pktCount), 64'(1));

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
